alu_result_buffer: RTL and testbench

//  Issue-side counterpart of the ALU: accepts ALU requests from issue over a valid/ready handshake,

---
 rtl/alu_result_buffer.sv | 106 ++++++++++
 tb/tb_alu_result_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// ALU result buffer: accepts ALU requests over valid/ready, captures each
// combinational ALU result into an in-order FIFO, and returns results with
// their trans_id over a second valid/ready handshake. The FIFO depth may be
// any integer >= 1, and a flush empties it.
module alu_result_buffer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 5,
  // Flat request word; the trans_id tag occupies bits [TRANS_ID_BITS-1:0].
  parameter int unsigned FU_DATA_W     = 32,
  parameter int unsigned DEPTH         = 2,
  localparam int unsigned PtrW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW         = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [FU_DATA_W-1:0]     fu_data_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  output logic [FU_DATA_W-1:0]     alu_fu_data_o,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic                     alu_branch_res_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_branch_res_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [CntW-1:0]          occupancy_o
);

  logic [XLEN-1:0]          result_q [DEPTH];
  logic                     branch_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_q     [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Handshakes, pass-through and head-of-queue outputs.
  always_comb begin
    alu_fu_data_o   = fu_data_i;
    wb_valid_o      = (count_q != '0);
    // A full buffer still accepts when the consumer is draining the head.
    alu_ready_o     = (count_q < CntW'(DEPTH)) | wb_ready_i;
    push            = alu_valid_i & alu_ready_o & ~flush_i;
    pop             = wb_valid_o & wb_ready_i & ~flush_i;
    wb_result_o     = result_q[rd_ptr_q];
    wb_branch_res_o = branch_q[rd_ptr_q];
    wb_trans_id_o   = id_q[rd_ptr_q];
    occupancy_o     = count_q;
  end

  // Next-state pointers and count; pointers wrap at DEPTH-1, not at 2^PtrW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so head outputs read zero, left as-is on flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i] <= '0;
        branch_q[i] <= 1'b0;
        id_q[i]     <= '0;
      end
    end else if (push) begin
      result_q[wr_ptr_q] <= alu_result_i;
      branch_q[wr_ptr_q] <= alu_branch_res_i;
      id_q[wr_ptr_q]     <= fu_data_i[TRANS_ID_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed stimulus pushes expected entries into
// a queue; a separate monitor pops and compares on every writeback handshake.
module tb_alu_result_buffer;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned IDW   = 5;
  localparam int unsigned FUW   = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            br;
    logic [IDW-1:0]  id;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [FUW-1:0]   fu_data;
  logic             alu_valid;
  logic             alu_ready;
  logic [FUW-1:0]   alu_fu_data;
  logic [XLEN-1:0]  alu_result;
  logic             alu_branch;
  logic             wb_valid;
  logic             wb_ready;
  logic [XLEN-1:0]  wb_result;
  logic             wb_branch;
  logic [IDW-1:0]   wb_id;
  logic [1:0]       occupancy;

  entry_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  alu_result_buffer #(
    .XLEN         (XLEN),
    .TRANS_ID_BITS(IDW),
    .FU_DATA_W    (FUW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .fu_data_i       (fu_data),
    .alu_valid_i     (alu_valid),
    .alu_ready_o     (alu_ready),
    .alu_fu_data_o   (alu_fu_data),
    .alu_result_i    (alu_result),
    .alu_branch_res_i(alu_branch),
    .wb_valid_o      (wb_valid),
    .wb_ready_i      (wb_ready),
    .wb_result_o     (wb_result),
    .wb_branch_res_o (wb_branch),
    .wb_trans_id_o   (wb_id),
    .occupancy_o     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every writeback handshake is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 64'(wb_id), 64'h1F1F);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        check("wb_result", wb_result, e.res);
        check("wb_branch", 64'(wb_branch), 64'(e.br));
        check("wb_trans_id", 64'(wb_id), 64'(e.id));
      end
    end
  end

  // Drive a request; the bench only asserts valid when it expects acceptance.
  task automatic set_req(input int id, input logic [XLEN-1:0] res);
    alu_valid  = 1'b1;
    fu_data    = 32'hA5A5_0000 | 32'(id);
    alu_result = res;
    alu_branch = id[0];
  endtask

  // One clock: record the expected entry for an accepted push, then land at posedge+1.
  task automatic step();
    entry_t e;
    @(negedge clk);
    if (rst_n && alu_valid && !flush) begin
      e.res = alu_result;
      e.br  = alu_branch;
      e.id  = fu_data[IDW-1:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    fu_data    = '0;
    alu_valid  = 1'b0;
    alu_result = '0;
    alu_branch = 1'b0;
    wb_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_valid", 64'(wb_valid), 64'd0);
      check("idle_ready", 64'(alu_ready), 64'd1);
      check("idle_occ", 64'(occupancy), 64'd0);
    end

    // Single push held under back-pressure, then drained.
    set_req(3, 64'h2A);
    #1 check("fu_passthru", 64'(alu_fu_data), 64'hA5A5_0003);
    step();
    alu_valid = 1'b0;
    check("t2_valid", 64'(wb_valid), 64'd1);
    check("t2_occ", 64'(occupancy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_hold_result", wb_result, 64'h2A);
      check("t2_hold_id", 64'(wb_id), 64'd3);
      check("t2_hold_valid", 64'(wb_valid), 64'd1);
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("t2_empty_valid", 64'(wb_valid), 64'd0);
    check("t2_empty_occ", 64'(occupancy), 64'd0);

    // Fill, then push into a full buffer while the head pops.
    set_req(1, 64'hFFFF_0000_0000_0011);
    step();
    set_req(2, 64'h8000_0000_0000_0022);
    step();
    alu_valid = 1'b0;
    check("t3_full_occ", 64'(occupancy), 64'd2);
    check("t3_full_ready", 64'(alu_ready), 64'd0);
    wb_ready = 1'b1;
    set_req(3, 64'h33);
    #1 check("t3_full_pop_ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 1'b0;
    check("t3_occ_after", 64'(occupancy), 64'd2);
    step();
    step();
    check("t3_drained_occ", 64'(occupancy), 64'd0);
    check("t3_drained_valid", 64'(wb_valid), 64'd0);

    // Streaming one result per cycle through wrapping pointers.
    for (int i = 0; i < 20; i++) begin
      set_req(i, {32'hDEAD_0000 | 32'(i), 32'(i * 3)});
      step();
      check("t4_stream_occ", 64'(occupancy), 64'd1);
    end
    alu_valid = 1'b0;
    step();
    check("t4_end_occ", 64'(occupancy), 64'd0);
    wb_ready = 1'b0;

    // Flush with a concurrent push and pop request.
    set_req(7, 64'h77);
    step();
    set_req(8, 64'h88);
    step();
    check("t5_pre_occ", 64'(occupancy), 64'd2);
    set_req(9, 64'h99);
    flush    = 1'b1;
    wb_ready = 1'b1;
    step();
    exp_q.delete();
    flush     = 1'b0;
    alu_valid = 1'b0;
    wb_ready  = 1'b0;
    check("t5_flush_occ", 64'(occupancy), 64'd0);
    check("t5_flush_valid", 64'(wb_valid), 64'd0);

    // Asynchronous reset mid-cycle with entries held.
    set_req(4, 64'h44);
    step();
    set_req(5, 64'h55);
    step();
    alu_valid = 1'b0;
    check("t6_pre_occ", 64'(occupancy), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(wb_valid), 64'd0);
    check("t6_rst_occ", 64'(occupancy), 64'd0);
    check("t6_rst_result", wb_result, 64'd0);
    check("t6_rst_id", 64'(wb_id), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("t6_post_ready", 64'(alu_ready), 64'd1);
    check("t6_post_occ", 64'(occupancy), 64'd0);

    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
